pmp_csr_regs: RTL and testbench

Holds the machine-mode physical memory protection CSRs (pmpcfg0–15, pmpaddr0–63) and drives the per-entry configuration and address arrays consumed by the PMP checker in the MMU. It is the stage directly upstream of the checker.
- Decodes CSR reads and writes from the CSR unit.
- Applies the privileged-spec WARL and lock rules.
- Emits a one-cycle update pulse after each effective change, so the hart can fence in-flight translations and fetches.

---
 rtl/pmp_csr_regs.sv | 144 ++++++++++++++
 tb/tb_pmp_csr_regs.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pmp_csr_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pmp_csr_regs                                                  |
// | Purpose  : Machine-mode PMP CSR file (pmpcfg0-15, pmpaddr0-63). Decodes  |
// |            CSR accesses, applies WARL/lock rules, and drives the         |
// |            per-entry cfg/address arrays for the PMP checker.             |
// | Ports    : clk, reset_n (sync, active-low)                               |
// |            CSRWriteM/CSRAdrM/CSRWriteValM - CSR write strobe/addr/data   |
// |            CSRReadValM       - combinational read data for CSRAdrM       |
// |            IllegalPMPAccessM - odd pmpcfg when XLEN=64                   |
// |            PMPUpdateM        - one-cycle pulse after a stored-bit change |
// |            PMPCFG_ARRAY_REGW / PMPADDR_ARRAY_REGW - per-entry state      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pmp_csr_regs #(
  parameter int PMP_ENTRIES = 16,
  parameter int PA_BITS     = 56,
  parameter int XLEN        = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               CSRWriteM,
  input  logic [11:0]        CSRAdrM,
  input  logic [XLEN-1:0]    CSRWriteValM,
  output logic [XLEN-1:0]    CSRReadValM,
  output logic               IllegalPMPAccessM,
  output logic               PMPUpdateM,
  output logic [7:0]         PMPCFG_ARRAY_REGW  [(PMP_ENTRIES > 0 ? PMP_ENTRIES : 1)-1:0],
  output logic [PA_BITS-3:0] PMPADDR_ARRAY_REGW [(PMP_ENTRIES > 0 ? PMP_ENTRIES : 1)-1:0]
);

  // Full 64-entry views with unimplemented entries tied to zero, so the read
  // mux can index with exactly 6 bits regardless of PMP_ENTRIES.
  logic [7:0]         cfg_all  [64];
  logic [PA_BITS-3:0] addr_all [64];

  logic       in_cfg;
  logic       in_addr;
  logic [5:0] addr_idx;
  logic [5:0] cfg_idx;

  assign in_cfg   = (CSRAdrM[11:4] == 8'h3A);
  assign in_addr  = (CSRAdrM >= 12'h3B0) && (CSRAdrM <= 12'h3EF);
  // 0x3B0 has low six bits 0x30; modulo-64 subtraction maps 0x3B0..0x3EF to 0..63.
  assign addr_idx = CSRAdrM[5:0] - 6'h30;

  assign IllegalPMPAccessM = in_cfg && (XLEN == 64) && CSRAdrM[0];

  always_comb begin
    CSRReadValM = '0;
    cfg_idx     = '0;
    if (in_cfg && !IllegalPMPAccessM) begin
      for (int j = 0; j < XLEN/8; j++) begin
        if (XLEN == 64) cfg_idx = {CSRAdrM[3:1], 3'(j)};
        else            cfg_idx = {CSRAdrM[3:0], 2'(j)};
        CSRReadValM[8*j +: 8] = cfg_all[cfg_idx];
      end
    end else if (in_addr) begin
      CSRReadValM = XLEN'(addr_all[addr_idx]);
    end
  end

  generate
    if (PMP_ENTRIES > 0) begin : g_pmp
      logic [7:0]             cfg_cur  [PMP_ENTRIES-1:0];
      logic [PA_BITS-3:0]     addr_cur [PMP_ENTRIES-1:0];
      logic [PMP_ENTRIES-1:0] chg;
      logic                   update_q;

      for (genvar i = 0; i < PMP_ENTRIES; i++) begin : g_entry
        localparam int          CFG_CSR  = (XLEN == 64) ? (i / 8) * 2 : i / 4;
        localparam int          BYTE_SEL = (XLEN == 64) ? i % 8 : i % 4;
        localparam logic [11:0] CFG_ADR  = 12'(12'h3A0 + CFG_CSR);
        localparam logic [11:0] ADDR_ADR = 12'(12'h3B0 + i);

        logic [7:0]         cfg_q, cfg_d, wbyte, legal;
        logic [PA_BITS-3:0] addr_q, addr_d;
        logic               tor_lock;

        assign wbyte = CSRWriteValM[8*BYTE_SEL +: 8];

        always_comb begin
          legal = wbyte & 8'b1001_1111;
          // W=1,R=0 is reserved: collapse to no access.
          if (wbyte[1] && !wbyte[0]) legal[1:0] = 2'b00;
        end

        // A locked TOR entry above also freezes this entry's address,
        // since it forms that region's lower bound.
        if (i + 1 < PMP_ENTRIES) begin : g_tor
          assign tor_lock = cfg_cur[i+1][7] && (cfg_cur[i+1][4:3] == 2'b01);
        end else begin : g_last
          assign tor_lock = 1'b0;
        end

        assign cfg_d  = (CSRWriteM && (CSRAdrM == CFG_ADR) && !cfg_q[7]) ? legal : cfg_q;
        assign addr_d = (CSRWriteM && (CSRAdrM == ADDR_ADR) && !cfg_q[7] && !tor_lock)
                        ? CSRWriteValM[PA_BITS-3:0] : addr_q;
        assign chg[i] = (cfg_d != cfg_q) || (addr_d != addr_q);

        always_ff @(posedge clk) begin
          if (!reset_n) begin
            cfg_q  <= '0;
            addr_q <= '0;
          end else begin
            cfg_q  <= cfg_d;
            addr_q <= addr_d;
          end
        end

        assign cfg_cur[i]            = cfg_q;
        assign addr_cur[i]           = addr_q;
        assign PMPCFG_ARRAY_REGW[i]  = cfg_q;
        assign PMPADDR_ARRAY_REGW[i] = addr_q;
      end

      for (genvar k = 0; k < 64; k++) begin : g_fill
        if (k < PMP_ENTRIES) begin : g_impl
          assign cfg_all[k]  = cfg_cur[k];
          assign addr_all[k] = addr_cur[k];
        end else begin : g_zero
          assign cfg_all[k]  = '0;
          assign addr_all[k] = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) update_q <= 1'b0;
        else          update_q <= |chg;
      end
      assign PMPUpdateM = update_q;
    end else begin : g_nopmp
      for (genvar k = 0; k < 64; k++) begin : g_fill
        assign cfg_all[k]  = '0;
        assign addr_all[k] = '0;
      end
      assign PMPCFG_ARRAY_REGW[0]  = '0;
      assign PMPADDR_ARRAY_REGW[0] = '0;
      assign PMPUpdateM            = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pmp_csr_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pmp_csr_regs                                               |
// | Purpose  : Directed self-checking bench for pmp_csr_regs (16 entries,    |
// |            PA_BITS=56, XLEN=64) with a queue-based scoreboard.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pmp_csr_regs;

  localparam int NE = 16;
  localparam int PA = 56;
  localparam int XL = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          CSRWriteM;
  logic [11:0]   CSRAdrM;
  logic [XL-1:0] CSRWriteValM;
  logic [XL-1:0] CSRReadValM;
  logic          IllegalPMPAccessM;
  logic          PMPUpdateM;
  logic [7:0]    cfg_arr  [NE-1:0];
  logic [PA-3:0] addr_arr [NE-1:0];

  typedef struct {
    string       tag;
    logic [63:0] val;
  } sb_t;
  sb_t sbq[$];

  int total = 0;
  int bad   = 0;

  pmp_csr_regs #(.PMP_ENTRIES(NE), .PA_BITS(PA), .XLEN(XL)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .CSRWriteM         (CSRWriteM),
    .CSRAdrM           (CSRAdrM),
    .CSRWriteValM      (CSRWriteValM),
    .CSRReadValM       (CSRReadValM),
    .IllegalPMPAccessM (IllegalPMPAccessM),
    .PMPUpdateM        (PMPUpdateM),
    .PMPCFG_ARRAY_REGW (cfg_arr),
    .PMPADDR_ARRAY_REGW(addr_arr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [63:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    sb_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // One-cycle write; PMPUpdateM is checked just after the committing edge.
  task automatic wr(input string tag, input logic [11:0] adr, input logic [63:0] v,
                    input logic exp_upd);
    @(negedge clk);
    CSRWriteM    = 1'b1;
    CSRAdrM      = adr;
    CSRWriteValM = v;
    push(tag, {63'd0, exp_upd});
    @(posedge clk);
    #1;
    CSRWriteM = 1'b0;
    check({63'd0, PMPUpdateM});
  endtask

  task automatic rd(input string tag, input logic [11:0] adr, input logic [63:0] exp);
    @(negedge clk);
    CSRWriteM = 1'b0;
    CSRAdrM   = adr;
    push(tag, exp);
    #1;
    check(CSRReadValM);
  endtask

  task automatic ill(input string tag, input logic [11:0] adr, input logic exp);
    @(negedge clk);
    CSRAdrM = adr;
    push(tag, {63'd0, exp});
    #1;
    check({63'd0, IllegalPMPAccessM});
  endtask

  task automatic idle_upd(input string tag);
    @(posedge clk);
    #1;
    push(tag, 64'd0);
    check({63'd0, PMPUpdateM});
  endtask

  initial begin
    reset_n      = 1'b0;
    CSRWriteM    = 1'b0;
    CSRAdrM      = 12'h000;
    CSRWriteValM = '0;
    repeat (2) @(posedge clk);
    #1;
    push("rst_upd", 64'd0);
    check({63'd0, PMPUpdateM});
    @(negedge clk);
    reset_n = 1'b1;

    rd("rst_cfg0", 12'h3A0, 64'd0);
    rd("rst_addr5", 12'h3B5, 64'd0);

    // WARL: 0x62 -> 0x00 (bits 6:5 cleared, W-without-R collapsed); 0x7F -> 0x1F
    wr("warl_upd", 12'h3A0, 64'h7F62, 1'b1);
    push("warl_e0", 64'h00); check({56'd0, cfg_arr[0]});
    push("warl_e1", 64'h1F); check({56'd0, cfg_arr[1]});
    rd("warl_rd", 12'h3A0, 64'h1F00);
    idle_upd("warl_pulse_end");
    wr("same_data_upd", 12'h3A0, 64'h7F62, 1'b0);

    // Entry1 locked TOR freezes pmpaddr0 and pmpaddr1
    wr("lock_upd", 12'h3A0, 64'h8800, 1'b1);
    push("lock_e1", 64'h88); check({56'd0, cfg_arr[1]});
    wr("tor_blk_upd", 12'h3B0, 64'h1234, 1'b0);
    rd("tor_blk_rd", 12'h3B0, 64'd0);
    wr("clr_lock_upd", 12'h3A0, 64'h0, 1'b0);
    rd("clr_lock_rd", 12'h3A0, 64'h8800);
    wr("self_lock_upd", 12'h3B1, 64'hAB, 1'b0);
    rd("self_lock_rd", 12'h3B1, 64'd0);
    wr("addr2_upd", 12'h3B2, 64'h55, 1'b1);
    rd("addr2_rd", 12'h3B2, 64'h55);
    // Bytes judged independently: entry0 writable while entry1 locked
    wr("indep_upd", 12'h3A0, 64'h0003, 1'b1);
    rd("indep_rd", 12'h3A0, 64'h8803);

    // Illegal odd pmpcfg
    ill("ill_3a1", 12'h3A1, 1'b1);
    rd("ill_rd", 12'h3A1, 64'd0);
    ill("ill_3a2", 12'h3A2, 1'b0);
    wr("ill_wr_upd", 12'h3A1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    rd("ill_wr_cfg0", 12'h3A0, 64'h8803);
    rd("ill_wr_cfg2", 12'h3A2, 64'd0);

    // Missing entries
    wr("miss_addr_upd", 12'h3C4, 64'hFFFF, 1'b0);
    rd("miss_addr_rd", 12'h3C4, 64'd0);
    ill("miss_addr_ill", 12'h3C4, 1'b0);
    wr("miss_cfg_upd", 12'h3A4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    rd("miss_cfg_rd", 12'h3A4, 64'd0);

    // Truncation to PA_BITS-2
    wr("trunc_upd", 12'h3B3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    rd("trunc_rd", 12'h3B3, 64'h003F_FFFF_FFFF_FFFF);
    push("trunc_arr", 64'h003F_FFFF_FFFF_FFFF); check({10'd0, addr_arr[3]});

    // Back-to-back changing writes pulse on consecutive cycles
    wr("b2b_1", 12'h3B5, 64'h1, 1'b1);
    wr("b2b_2", 12'h3B5, 64'h2, 1'b1);
    idle_upd("b2b_end");
    rd("b2b_rd", 12'h3B5, 64'h2);

    // Lock with A=OFF on entry8 protects only its own address
    wr("l8_upd", 12'h3A2, 64'h80, 1'b1);
    wr("l8_self_upd", 12'h3B8, 64'h99, 1'b0);
    rd("l8_self_rd", 12'h3B8, 64'd0);
    wr("l8_below_upd", 12'h3B7, 64'h99, 1'b1);
    rd("l8_below_rd", 12'h3B7, 64'h99);

    // Reset wins over a coincident write; the next edge commits it
    @(negedge clk);
    reset_n      = 1'b0;
    CSRWriteM    = 1'b1;
    CSRAdrM      = 12'h3B4;
    CSRWriteValM = 64'h77;
    @(posedge clk);
    #1;
    push("rstw_rd", 64'd0);  check(CSRReadValM);
    push("rstw_upd", 64'd0); check({63'd0, PMPUpdateM});
    push("rstw_e1", 64'd0);  check({56'd0, cfg_arr[1]});
    push("rstw_a2", 64'd0);  check({10'd0, addr_arr[2]});
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    CSRWriteM = 1'b0;
    push("rstw2_upd", 64'd1); check({63'd0, PMPUpdateM});
    push("rstw2_rd", 64'h77); check(CSRReadValM);
    // Locks cleared by reset: pmpaddr0 writable again
    wr("unlock_upd", 12'h3B0, 64'h10, 1'b1);
    rd("unlock_rd", 12'h3B0, 64'h10);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
